// File: rtl/board_io_ctrl_if.sv
// Board I/O signal bundle: core-side triggers/UART and pin-side switches.
// The block under control uses the slave modport; the driver of its inputs uses master.
interface board_io_ctrl_if #(
   parameter int unsigned NTRIG = 4,
   parameter int unsigned NSW   = 8
);
   logic [1:0]       trig_mode;
   logic [NTRIG-1:0] trig_in;
   logic [NTRIG-1:0] trig_out;
   logic             uart_tx_in;
   logic             uart_rx_in;
   logic             led_tx;
   logic             led_rx;
   logic [NSW-1:0]   sw_raw;
   logic [NSW-1:0]   sw_db;
   logic             sw_chg;

   modport master (
      output trig_mode, trig_in, uart_tx_in, uart_rx_in, sw_raw,
      input  trig_out, led_tx, led_rx, sw_db, sw_chg
   );

   modport slave (
      input  trig_mode, trig_in, uart_tx_in, uart_rx_in, sw_raw,
      output trig_out, led_tx, led_rx, sw_db, sw_chg
   );
endinterface

// File: rtl/board_io_ctrl.sv
// Trigger conditioning, UART activity LEDs and switch synchronisation for the board.
// Define BOARD_IO_DEBOUNCE_EN to add a per-switch DEB_CYC stability filter.
module board_io_ctrl #(
   parameter int unsigned NTRIG   = 4,
   parameter int unsigned STRETCH = 48,
   parameter int unsigned ACT_LEN = 2400000,
   parameter int unsigned NSW     = 8,
   parameter int unsigned DEB_CYC = 480000
) (
   input logic            clk,
   input logic            resetn,
   board_io_ctrl_if.slave io
);

   localparam int unsigned AW = $clog2(ACT_LEN + 1);

   if (STRETCH < 1 || STRETCH > 65535 || ACT_LEN < 1 || DEB_CYC < 2) begin : g_param_chk
      $error("board_io_ctrl: parameter out of range");
   end

   // ---------------------------------------------------------------- triggers
   logic [1:0]       mode_q;
   logic             mode_chg;
   logic [NTRIG-1:0] prev_q;
   logic [NTRIG-1:0] rise;
   logic [NTRIG-1:0] out_q;
   logic [NTRIG-1:0] out_d;
   logic [15:0]      cnt_q [NTRIG];
   logic [15:0]      cnt_d [NTRIG];

   assign mode_chg = (io.trig_mode != mode_q);
   assign rise     = io.trig_in & ~prev_q;

   always_comb begin
      out_d = out_q;
      for (int i = 0; i < NTRIG; i++) begin
         cnt_d[i] = cnt_q[i];
         case (mode_q)
            2'b01: begin
               if (rise[i]) begin
                  cnt_d[i] = 16'(STRETCH);
               end else if (cnt_q[i] != '0) begin
                  cnt_d[i] = cnt_q[i] - 16'd1;
               end
               out_d[i] = (cnt_d[i] != '0);
            end
            2'b10:   out_d[i] = out_q[i] ^ rise[i];
            default: out_d[i] = io.trig_in[i];
         endcase
         // A mode switch wipes the channel and discards this cycle's edges.
         if (mode_chg) begin
            cnt_d[i] = '0;
            out_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mode_q <= 2'b00;
         prev_q <= '0;
         out_q  <= '0;
         for (int i = 0; i < NTRIG; i++) cnt_q[i] <= '0;
      end else begin
         mode_q <= io.trig_mode;
         prev_q <= mode_chg ? '0 : io.trig_in;
         out_q  <= out_d;
         for (int i = 0; i < NTRIG; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign io.trig_out = out_q;

   // ---------------------------------------------------------------- UART LEDs
   // Index 0 is TX, index 1 is RX. Sync and history flops reset high so an idle
   // line never looks like a start bit after reset.
   logic [1:0]    u_raw;
   logic [1:0]    u_s1_q;
   logic [1:0]    u_s2_q;
   logic [1:0]    u_prev_q;
   logic [1:0]    u_fall;
   logic [AW-1:0] act_q [2];
   logic [AW-1:0] act_d [2];

   assign u_raw  = {io.uart_rx_in, io.uart_tx_in};
   assign u_fall = u_prev_q & ~u_s2_q;

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         act_d[k] = act_q[k];
         if (u_fall[k]) begin
            act_d[k] = AW'(ACT_LEN);
         end else if (act_q[k] != '0) begin
            act_d[k] = act_q[k] - AW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         u_s1_q   <= '1;
         u_s2_q   <= '1;
         u_prev_q <= '1;
         for (int k = 0; k < 2; k++) act_q[k] <= '0;
      end else begin
         u_s1_q   <= u_raw;
         u_s2_q   <= u_s1_q;
         u_prev_q <= u_s2_q;
         for (int k = 0; k < 2; k++) act_q[k] <= act_d[k];
      end
   end

   assign io.led_tx = (act_q[0] != '0);
   assign io.led_rx = (act_q[1] != '0);

   // ---------------------------------------------------------------- switches
   logic [NSW-1:0] sw_s1_q;
   logic [NSW-1:0] sw_s2_q;
   logic [NSW-1:0] db_val;
   logic [NSW-1:0] db_prev_q;
   logic           chg_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sw_s1_q <= '0;
         sw_s2_q <= '0;
      end else begin
         sw_s1_q <= io.sw_raw;
         sw_s2_q <= sw_s1_q;
      end
   end

`ifdef BOARD_IO_DEBOUNCE_EN
   localparam int unsigned DW = $clog2(DEB_CYC);

   logic [NSW-1:0] db_q;
   logic [NSW-1:0] db_d;
   logic [DW-1:0]  deb_q [NSW];
   logic [DW-1:0]  deb_d [NSW];

   // Counter tracks consecutive disagreeing cycles; any agreement restarts it.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < NSW; i++) begin
         deb_d[i] = '0;
         if (sw_s2_q[i] != db_q[i]) begin
            if (deb_q[i] == DW'(DEB_CYC - 1)) begin
               db_d[i] = sw_s2_q[i];
            end else begin
               deb_d[i] = deb_q[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         db_q <= '0;
         for (int i = 0; i < NSW; i++) deb_q[i] <= '0;
      end else begin
         db_q <= db_d;
         for (int i = 0; i < NSW; i++) deb_q[i] <= deb_d[i];
      end
   end

   assign db_val = db_q;
`else
   assign db_val = sw_s2_q;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         db_prev_q <= '0;
         chg_q     <= 1'b0;
      end else begin
         db_prev_q <= db_val;
         chg_q     <= |(db_val ^ db_prev_q);
      end
   end

   assign io.sw_db  = db_val;
   assign io.sw_chg = chg_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Randomised scoreboard bench for board_io_ctrl; the reference model reasons in terms of
// edge times, fall times and stability windows rather than counters.
module tb_board_io_ctrl;
   localparam int NTRIG   = 4;
   localparam int STRETCH = 48;
   localparam int ACT_LEN = 100;
   localparam int NSW     = 8;
   localparam int DEB_CYC = 16;
   localparam int HMAX    = 16384;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   board_io_ctrl_if #(.NTRIG(NTRIG), .NSW(NSW)) bus ();

   board_io_ctrl #(
      .NTRIG  (NTRIG),
      .STRETCH(STRETCH),
      .ACT_LEN(ACT_LEN),
      .NSW    (NSW),
      .DEB_CYC(DEB_CYC)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .io    (bus)
   );

   typedef struct {
      int               cyc;
      logic [NTRIG-1:0] trig;
      logic             tx;
      logic             rx;
      logic [NSW-1:0]   db;
      logic             chg;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   // stimulus values for the current cycle
   logic [1:0]       m_mode;
   logic [NTRIG-1:0] m_trig;
   logic             m_tx, m_rx;
   logic [NSW-1:0]   m_sw;

   // reference model state
   int               cyc = 0;
   int               epoch = 0;
   logic [NSW-1:0]   h_sw [HMAX];
   logic [NSW-1:0]   h_db [HMAX];
   logic [1:0]       mq;
   logic [NTRIG-1:0] tprev;
   int               last_edge [NTRIG];
   int               nedge [NTRIG];
   logic             tx_last, rx_last;
   int               tx_falls[$];
   int               rx_falls[$];
   int               db_last [NSW];

   task automatic chk(input string name, input int at, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, at, act, req);
      end
   endtask

   // Synchronised switch value seen by the block in period t.
   function automatic logic [NSW-1:0] s2(input int t);
      if (t - 2 >= epoch) return h_sw[(t - 2) % HMAX];
      return '0;
   endfunction

   task automatic model_reset();
      epoch = cyc;
      mq    = 2'b00;
      tprev = '0;
      for (int c = 0; c < NTRIG; c++) begin
         last_edge[c] = -100000;
         nedge[c]     = 0;
      end
      tx_last = 1'b1;
      rx_last = 1'b1;
      tx_falls.delete();
      rx_falls.delete();
      for (int b = 0; b < NSW; b++) db_last[b] = cyc;
      h_db[cyc % HMAX] = '0;
   endtask

   // Drive this cycle's inputs, predict the outputs of the next cycle, advance.
   task automatic tick();
      int             j, k;
      exp_t           e;
      logic [NSW-1:0] dbn;
      bit             ok;
      j = cyc;
      k = cyc + 1;
      bus.trig_mode  = m_mode;
      bus.trig_in    = m_trig;
      bus.uart_tx_in = m_tx;
      bus.uart_rx_in = m_rx;
      bus.sw_raw     = m_sw;
      h_sw[j % HMAX] = m_sw;
      e.cyc = k;

      if (m_mode != mq) begin
         mq     = m_mode;
         tprev  = '0;
         e.trig = '0;
         for (int c = 0; c < NTRIG; c++) begin
            last_edge[c] = -100000;
            nedge[c]     = 0;
         end
      end else begin
         for (int c = 0; c < NTRIG; c++) begin
            if (m_trig[c] && !tprev[c]) begin
               last_edge[c] = j;
               nedge[c]++;
            end
            case (mq)
               2'b01:   e.trig[c] = (k - last_edge[c] <= STRETCH);
               2'b10:   e.trig[c] = (nedge[c] % 2 == 1);
               default: e.trig[c] = m_trig[c];
            endcase
         end
         tprev = m_trig;
      end

      // LED lit from 3 to ACT_LEN+2 cycles after any line fall
      if (!m_tx && tx_last) tx_falls.push_back(j);
      tx_last = m_tx;
      while (tx_falls.size() > 0 && k - tx_falls[0] > ACT_LEN + 2) tx_falls.delete(0);
      e.tx = 1'b0;
      foreach (tx_falls[i]) if (k - tx_falls[i] >= 3) e.tx = 1'b1;
      if (!m_rx && rx_last) rx_falls.push_back(j);
      rx_last = m_rx;
      while (rx_falls.size() > 0 && k - rx_falls[0] > ACT_LEN + 2) rx_falls.delete(0);
      e.rx = 1'b0;
      foreach (rx_falls[i]) if (k - rx_falls[i] >= 3) e.rx = 1'b1;

`ifdef BOARD_IO_DEBOUNCE_EN
      dbn = h_db[j % HMAX];
      for (int b = 0; b < NSW; b++) begin
         ok = (j - DEB_CYC + 1 >= db_last[b]);
         for (int t = j - DEB_CYC + 1; t <= j && ok; t++) begin
            logic [NSW-1:0] sv;
            sv = s2(t);
            if (sv[b] == dbn[b]) ok = 1'b0;
         end
         if (ok) begin
            dbn[b]     = ~dbn[b];
            db_last[b] = k;
         end
      end
`else
      ok  = 1'b0;
      dbn = s2(k);
`endif
      h_db[k % HMAX] = dbn;
      e.db  = dbn;
      e.chg = (k - 2 >= epoch) && (h_db[(k - 1) % HMAX] != h_db[(k - 2) % HMAX]);
      sb_q.push_back(e);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      m_trig = '0;
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(input int ch);
      m_trig     = '0;
      m_trig[ch] = 1'b1;
      tick();
      m_trig = '0;
   endtask

   // Assert reset asynchronously at a falling clock edge, check, then release.
   task automatic do_reset(input int hold);
      resetn = 1'b0;
      #1;
      chk("rst_trig_out", cyc, 32'(bus.trig_out), 32'd0);
      chk("rst_led_tx", cyc, 32'(bus.led_tx), 32'd0);
      chk("rst_led_rx", cyc, 32'(bus.led_rx), 32'd0);
      chk("rst_sw_db", cyc, 32'(bus.sw_db), 32'd0);
      chk("rst_sw_chg", cyc, 32'(bus.sw_chg), 32'd0);
      sb_q.delete();
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         cyc++;
         chk("rst_hold_trig_out", cyc, 32'(bus.trig_out), 32'd0);
         chk("rst_hold_leds", cyc, 32'({bus.led_tx, bus.led_rx}), 32'd0);
      end
      model_reset();
      resetn = 1'b1;
   endtask

   // Monitor: compare the DUT against the oldest prediction each cycle.
   always begin : monitor
      exp_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         chk("trig_out", e.cyc, 32'(bus.trig_out), 32'(e.trig));
         chk("led_tx", e.cyc, 32'(bus.led_tx), 32'(e.tx));
         chk("led_rx", e.cyc, 32'(bus.led_rx), 32'(e.rx));
         chk("sw_db", e.cyc, 32'(bus.sw_db), 32'(e.db));
         chk("sw_chg", e.cyc, 32'(bus.sw_chg), 32'(e.chg));
      end
   end

   initial begin
      m_mode = 2'b00;
      m_trig = '0;
      m_tx   = 1'b1;
      m_rx   = 1'b1;
      m_sw   = '0;
      bus.trig_mode  = m_mode;
      bus.trig_in    = m_trig;
      bus.uart_tx_in = m_tx;
      bus.uart_rx_in = m_rx;
      bus.sw_raw     = m_sw;
      @(negedge clk);
      do_reset(4);
      idle(5);

      // stretch: single pulse, then two pulses 30 cycles apart
      m_mode = 2'b01;
      idle(3);
      pulse(2);
      idle(60);
      pulse(1);
      idle(29);
      pulse(1);
      idle(60);
      m_trig = 4'b1000;
      for (int i = 0; i < 70; i++) tick();
      idle(5);

      // toggle: three pulses, then back to pass
      m_mode = 2'b10;
      idle(3);
      for (int p = 0; p < 3; p++) begin
         pulse(0);
         idle(4);
      end
      m_mode = 2'b00;
      for (int i = 0; i < 40; i++) begin
         m_trig = 4'($urandom_range(0, 15));
         tick();
      end
      m_mode = 2'b11;
      for (int i = 0; i < 20; i++) begin
         m_trig = 4'($urandom_range(0, 15));
         tick();
      end
      m_mode = 2'b00;
      idle(5);

      // UART: rx low for 10 cycles, later a short tx burst
      m_rx = 1'b0;
      idle(10);
      m_rx = 1'b1;
      idle(110);
      for (int i = 0; i < 12; i++) begin
         m_tx = (i % 3 != 0);
         tick();
      end
      m_tx = 1'b1;
      idle(110);

      // switch 3 bounces five times within 10 cycles, then settles
      for (int i = 0; i < 10; i++) begin
         m_sw[3] = (i % 2 == 0);
         tick();
      end
      m_sw[3] = 1'b1;
      idle(30);
      m_sw[3] = 1'b0;
      idle(30);
      m_sw = 8'hA5;
      idle(25);

      // random traffic across all modes
      for (int m = 0; m < 4; m++) begin
         m_mode = 2'(m);
         for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 199) == 0) m_mode = 2'($urandom_range(0, 3));
            for (int c = 0; c < NTRIG; c++) if ($urandom_range(0, 7) == 0) m_trig[c] = ~m_trig[c];
            if ($urandom_range(0, 39) == 0) m_tx = ~m_tx;
            if ($urandom_range(0, 39) == 0) m_rx = ~m_rx;
            for (int b = 0; b < NSW; b++) if ($urandom_range(0, 39) == 0) m_sw[b] = ~m_sw[b];
            tick();
         end
      end

      // reset in the middle of a stretch, then idle inputs
      m_mode = 2'b01;
      m_tx   = 1'b1;
      m_rx   = 1'b1;
      m_sw   = '0;
      idle(30);
      pulse(3);
      idle(10);
      do_reset(3);
      m_mode = 2'b00;
      idle(150);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
